// File: rtl/m68k_bus_arbiter_if.sv
// Handshake bundle between the Pi transaction engine, the 68000 bus pins
// and the bus arbiter.
interface m68k_bus_arbiter_if;
  logic txn_req;
  logic txn_busy;
  logic M68K_BR_n;
  logic M68K_BGACK_n;
  logic M68K_AS_n;
  logic txn_grant;
  logic M68K_BG_n;
  logic bus_drive_en;
  logic grant_timeout;

  // Arbiter side: consumes requests and pin levels, produces grants.
  modport master (
    input  txn_req,
    input  txn_busy,
    input  M68K_BR_n,
    input  M68K_BGACK_n,
    input  M68K_AS_n,
    output txn_grant,
    output M68K_BG_n,
    output bus_drive_en,
    output grant_timeout
  );

  // Environment side: register interface, bus engine and external pins.
  modport slave (
    output txn_req,
    output txn_busy,
    output M68K_BR_n,
    output M68K_BGACK_n,
    output M68K_AS_n,
    input  txn_grant,
    input  M68K_BG_n,
    input  bus_drive_en,
    input  grant_timeout
  );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus ownership arbiter: Pi transaction engine versus external masters
// via BR/BG/BGACK, with a bounded Pi burst and an unacknowledged-grant timeout.
module m68k_bus_arbiter #(
  parameter int unsigned BR_FILT       = 2,
  parameter int unsigned MAX_PI_BURST  = 4,
  parameter int unsigned GRANT_TIMEOUT = 255
) (
  input logic                c200m,
  input logic                rst,
  m68k_bus_arbiter_if.master bus
);
  localparam int unsigned BR_CW   = $clog2(BR_FILT + 1);
  localparam int unsigned WAIT_CW = $clog2(GRANT_TIMEOUT + 1);
  localparam int unsigned BURST_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PI_START = 3'd1;
  localparam logic [2:0] ST_PI_RUN   = 3'd2;
  localparam logic [2:0] ST_GRANT    = 3'd3;
  localparam logic [2:0] ST_EXT      = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic               br_meta;
  logic               br_s;
  logic               bgack_meta;
  logic               bgack_s;
  logic               as_meta;
  logic               as_s;
  logic [BR_CW-1:0]   br_cnt;
  logic               br_valid;
  logic [BURST_W-1:0] pi_burst_cnt;
  logic [WAIT_CW-1:0] wait_cnt;
  logic               burst_at_max;
  logic               wait_done;
  logic               txn_done;
  logic               ext_entry;
  logic               timeout_nxt;

  assign burst_at_max = (pi_burst_cnt == BURST_W'(MAX_PI_BURST));
  assign wait_done    = (wait_cnt == WAIT_CW'(GRANT_TIMEOUT - 1));
  assign txn_done     = (state == ST_PI_RUN) && !bus.txn_busy;
  assign ext_entry    = (state == ST_GRANT) && (state_nxt == ST_EXT);

  // Two-flop synchronizers for the asynchronous bus pins; idle level is high.
  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      br_meta    <= 1'b1;
      br_s       <= 1'b1;
      bgack_meta <= 1'b1;
      bgack_s    <= 1'b1;
      as_meta    <= 1'b1;
      as_s       <= 1'b1;
    end else begin
      br_meta    <= bus.M68K_BR_n;
      br_s       <= br_meta;
      bgack_meta <= bus.M68K_BGACK_n;
      bgack_s    <= bgack_meta;
      as_meta    <= bus.M68K_AS_n;
      as_s       <= as_meta;
    end
  end

  // BR glitch filter: request is valid after BR_FILT consecutive low cycles.
  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      br_cnt   <= '0;
      br_valid <= 1'b0;
    end else if (br_s) begin
      br_cnt   <= '0;
      br_valid <= 1'b0;
    end else begin
      if (br_cnt != BR_CW'(BR_FILT)) br_cnt <= br_cnt + BR_CW'(1);
      if (br_cnt == BR_CW'(BR_FILT - 1)) br_valid <= 1'b1;
    end
  end

  // Back-to-back Pi transactions completed while an external request waits.
  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      pi_burst_cnt <= '0;
    end else if (ext_entry) begin
      pi_burst_cnt <= '0;
    end else if (txn_done) begin
      if (!br_valid)         pi_burst_cnt <= '0;
      else if (!burst_at_max) pi_burst_cnt <= pi_burst_cnt + BURST_W'(1);
    end
  end

  // Cycles spent in GRANT waiting for BGACK; zero in every other state.
  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == ST_GRANT) && (state_nxt == ST_GRANT)) begin
      wait_cnt <= wait_cnt + WAIT_CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Next-state logic; BR wins in IDLE only at the burst limit or with no Pi request.
  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_valid && (!bus.txn_req || burst_at_max) && as_s) begin
          state_nxt = ST_GRANT;
        end else if (bus.txn_req && bgack_s) begin
          state_nxt = ST_PI_START;
        end
      end
      ST_PI_START: begin
        if (bus.txn_busy) state_nxt = ST_PI_RUN;
      end
      ST_PI_RUN: begin
        if (!bus.txn_busy) state_nxt = ST_IDLE;
      end
      ST_GRANT: begin
        if (!bgack_s && as_s) begin
          state_nxt = ST_EXT;
        end else if (wait_done) begin
          state_nxt   = ST_IDLE;
          timeout_nxt = 1'b1;
        end
      end
      ST_EXT: begin
        if (bgack_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the state being entered.
  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      bus.txn_grant     <= 1'b0;
      bus.M68K_BG_n     <= 1'b1;
      bus.bus_drive_en  <= 1'b1;
      bus.grant_timeout <= 1'b0;
    end else begin
      state             <= state_nxt;
      bus.txn_grant     <= (state_nxt == ST_PI_START);
      bus.M68K_BG_n     <= (state_nxt != ST_GRANT);
      bus.bus_drive_en  <= (state_nxt == ST_IDLE) || (state_nxt == ST_PI_START) ||
                           (state_nxt == ST_PI_RUN);
      bus.grant_timeout <= timeout_nxt;
    end
  end
endmodule
